// File: rtl/mac_sat.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mac_sat
// Purpose  : Pipelined signed multiply-accumulate over N terms with a guarded
//            accumulator, rounding right shift and output saturation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_sat #(
    parameter int XW = 18,
    parameter int AW = 36,
    parameter int GW = 6,
    parameter int NW = 6,
    parameter int SW = 6,
    parameter int YW = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stf_i,
    input  logic [NW-1:0]        n_i,
    input  logic [SW-1:0]        s_i,
    input  logic                 rnd_i,
    input  logic signed [XW-1:0] x_i,
    input  logic signed [AW-1:0] a_i,
    output logic [NW-1:0]        i_o,
    output logic signed [YW-1:0] y_o,
    output logic                 ovf_o,
    output logic                 busy_o,
    output logic                 eof_o
);

    localparam int c_mw = XW + AW;
    localparam int c_pw = XW + AW + GW;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;
    localparam logic [1:0] c_out   = 2'd3;

    localparam logic signed [YW-1:0] c_y_max = {1'b0, {(YW-1){1'b1}}};
    localparam logic signed [YW-1:0] c_y_min = {1'b1, {(YW-1){1'b0}}};
    localparam logic [c_pw:0]        c_one   = {{c_pw{1'b0}}, 1'b1};

    logic [1:0]               r_state;
    logic [NW-1:0]            r_n;
    logic [NW-1:0]            r_idx;
    logic [SW-1:0]            r_s;
    logic                     r_rnd;
    logic                     r_pvld;
    logic signed [c_mw-1:0]   r_prod;
    logic signed [c_pw-1:0]   r_acc;
    logic signed [YW-1:0]     r_y;
    logic                     r_ovf;
    logic                     r_eof;

    logic signed [c_mw-1:0]   w_prod;
    logic [31:0]              w_s_ext;
    logic [31:0]              w_s_eff;
    logic [c_pw:0]            w_rnd;
    logic signed [c_pw:0]     w_sum;
    logic signed [c_pw:0]     w_shr;
    logic [c_pw-YW+1:0]       w_hi;
    logic                     w_clip;
    logic signed [YW-1:0]     w_y_sat;

    assign w_prod = x_i * a_i;

    // Shifts at or beyond the accumulator width collapse to the sign bit.
    assign w_s_ext = 32'(r_s);
    assign w_s_eff = (w_s_ext >= 32'(c_pw)) ? 32'(c_pw - 1) : w_s_ext;

    always_comb begin
        w_rnd = '0;
        if (r_rnd && (w_s_eff != 32'd0)) begin
            w_rnd = c_one << (w_s_eff - 32'd1);
        end
    end

    // One extra bit keeps the rounding offset from overflowing a full-scale sum.
    assign w_sum   = {r_acc[c_pw-1], r_acc} + w_rnd;
    assign w_shr   = w_sum >>> w_s_eff;
    assign w_hi    = w_shr[c_pw:YW-1];
    assign w_clip  = !((&w_hi) || (~|w_hi));
    assign w_y_sat = !w_clip ? w_shr[YW-1:0]
                   : (w_shr[c_pw] ? c_y_min : c_y_max);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_idle;
            r_n     <= '0;
            r_idx   <= '0;
            r_s     <= '0;
            r_rnd   <= 1'b0;
            r_pvld  <= 1'b0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_ovf   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_eof <= 1'b0;
            // Accumulation trails the product register by one edge in every state.
            if (r_pvld) begin
                r_acc <= r_acc + {{GW{r_prod[c_mw-1]}}, r_prod};
            end
            case (r_state)
                c_idle: begin
                    if (stf_i) begin
                        r_n     <= n_i;
                        r_s     <= s_i;
                        r_rnd   <= rnd_i;
                        r_acc   <= '0;
                        r_pvld  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= (n_i == '0) ? c_flush : c_run;
                    end
                end
                c_run: begin
                    r_prod <= w_prod;
                    r_pvld <= 1'b1;
                    if (r_idx == (r_n - NW'(1))) begin
                        r_idx   <= '0;
                        r_state <= c_flush;
                    end else begin
                        r_idx <= r_idx + NW'(1);
                    end
                end
                c_flush: begin
                    r_pvld  <= 1'b0;
                    r_state <= c_out;
                end
                c_out: begin
                    r_y     <= w_y_sat;
                    r_ovf   <= w_clip;
                    r_eof   <= 1'b1;
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign i_o    = r_idx;
    assign y_o    = r_y;
    assign ovf_o  = r_ovf;
    assign eof_o  = r_eof;
    assign busy_o = (r_state != c_idle);

endmodule
`default_nettype wire

// File: doc/mac_sat.md
# mac_sat

Parametrised, pipelined signed multiply-accumulate engine with a start/end handshake. After a start pulse it issues term indices 0..N-1, accumulates x·a over N terms in a guarded accumulator, then scales the sum by an arithmetic right shift with optional round-to-nearest and saturates it to the output width. It drives coefficient/sample memories through `i_o` and sits between those memories and the downstream filter/datapath logic, replacing the fixed-width MAC of earlier designs.

## Interface
- `XW`, 18: sample width (signed)
- `AW`, 36: coefficient width (signed)
- `GW`, 6: accumulator guard bits. Accumulator width `PW = XW + AW + GW`.
- `NW`, 6: term-count/index width
- `SW`, 6: shift-amount width
- `YW`, 18: output width (signed)
- `clk_i`  in  1  clock. Everything is on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high
- `stf_i`  in  1  start pulse. Sampled only in IDLE.
- `n_i`  in  NW  term count N, captured at start
- `s_i`  in  SW  right-shift amount S, captured at start
- `rnd_i`  in  1  rounding mode, captured at start: 1 = round-to-nearest, 0 = truncate
- `x_i`  in  XW  sample for the current `i_o`. Valid in the same cycle as `i_o` (combinational read).
- `a_i`  in  AW  coefficient for the current `i_o`. Same timing as `x_i`.
- `i_o`  out  NW  term index
- `y_o`  out  YW  scaled, saturated result. Holds until the next result.
- `ovf_o`  out  1  1 = `y_o` was saturated. Updates together with `y_o`.
- `busy_o`  out  1  1 when the state is not IDLE
- `eof_o`  out  1  one-cycle pulse; marks a new valid `y_o`

## Operation
- **States:** IDLE → RUN → FLUSH → OUT → IDLE.
- **IDLE:** `i_o` = 0.
  - When `stf_i` = 1: capture N, S and rnd; clear the accumulator and the pipeline valid bit.
  - Next state is RUN if N > 0, FLUSH if N = 0.
- **RUN:** lasts N cycles and presents `i_o` = 0, 1, …, N-1.
  - Each cycle, the full-precision product `x_i·a_i` (XW+AW bits, signed) is registered together with valid bit = 1.
  - After the cycle with `i_o` = N-1, go to FLUSH and return `i_o` to 0.
- **Accumulate:** every edge where the product-valid bit is 1, `acc <= acc + sext(p)`.
  - Arithmetic is in PW bits and wraps silently.
  - N ≤ 2^GW guarantees no wrap.
- **FLUSH:** one cycle. Performs the last accumulate and clears the valid bit. Next state is OUT.
- **OUT:** one cycle. At its closing edge:
  - `y_o <= sat_YW((acc + R) >>> S)`, where R = 2^(S-1) if rnd = 1 and S > 0, otherwise R = 0.
  - The rounding add is done in PW+1 bits.
  - S ≥ PW behaves as S = PW-1.
  - `ovf_o <= 1` if the value was clipped to +2^(YW-1)-1 or -2^(YW-1), otherwise 0.
  - `eof_o <= 1` for exactly one cycle; state goes to IDLE.
- **Start while busy:** `stf_i` outside IDLE is ignored.
- **Back-to-back runs:** `stf_i` = 1 in the same cycle `eof_o` = 1 is accepted (the state is already IDLE).
- **Reset mid-run:** `rst_i` at any time aborts the run. No `eof_o` is produced for the aborted run.

## Timing
- Reset values:
  - state = IDLE
  - `i_o` = 0, `y_o` = 0, `ovf_o` = 0, `busy_o` = 0, `eof_o` = 0
  - accumulator, product register and valid bit = 0
- Let E0 be the edge that samples `stf_i` = 1.
  - Index k is presented during the cycle after E(k), for k = 0..N-1.
  - Its product is registered at E(k+1) and accumulated at E(k+2).
- FLUSH is the cycle after E(N); OUT is the cycle after E(N+1).
- `y_o`, `ovf_o` and `eof_o` change at E(N+2). Latency from start to `eof_o` is N+2 edges; for N = 0 it is 2 edges, with `y_o` = 0.
- `busy_o` is high from after E0 until E(N+2), and low in the `eof_o` cycle.

## Test plan
- N=4, x = 1,2,3,4, a = 1, S=0, rnd=0:
  - `i_o` steps 0..3.
  - `eof_o` pulses at E6 with `y_o` = 10, `ovf_o` = 0.
  - `busy_o` is high for exactly 6 cycles.
- N=1, x=5, a=1, S=1: rnd=0 → `y_o` = 2; rnd=1 → `y_o` = 3. With x=-3: rnd=0 → -2; rnd=1 → -1.
- Saturation, N=1, S=0:
  - x = 131071, a = 2^20 → `y_o` = 131071, `ovf_o` = 1.
  - x = -131072, a = 2^20 → `y_o` = -131072, `ovf_o` = 1.
- N=0 → `eof_o` at E2 with `y_o` = 0.
- Pulse `stf_i` during RUN → ignored; the result equals that of an undisturbed run.
- Assert `rst_i` mid-RUN, then restart with N=2, x = 7,7, a = 1 → no stale contribution; `y_o` = 14 and `ovf_o` = 0 at E4.
